reg_cmd_ctrl: RTL and testbench

- Byte-stream command sequencer in front of the 8-entry configuration register file.
- Accepts command/data bytes from the host receiver over a valid/ready handshake and decodes read/write commands.
- Drives the register file address, write data and write enable; returns read data as a response byte over a second valid/ready handshake.
- Sole master of the register file write port.

---
 rtl/reg_cmd_ctrl_pkg.sv | 20 ++
 rtl/reg_cmd_ctrl_if.sv | 19 +
 rtl/reg_cmd_timeout.sv | 31 +++
 rtl/reg_cmd_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared types and constants for the register-file command sequencer.
package reg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    SEND     = 3'd4
  } state_e;

  localparam int         CMD_WR_BIT   = 7;
  localparam int         REG_MAX_ADDR = 8;
  localparam logic [7:0] RD_ERR_DATA  = 8'h00;

  function automatic logic addr_invalid(input logic [6:0] addr, input int max_addr);
    return ({25'd0, addr} >= 32'(max_addr));
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// Host byte-stream handshakes: command/data in (rx) and response out (tx).
interface reg_cmd_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/reg_cmd_timeout.sv
// Idle counter for the write-data wait; flags expiry when the count would reach TIMEOUT_CYC-1.
module reg_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expire_o
);

  localparam logic [10:0] LIMIT = 11'(TIMEOUT_CYC - 1);

  logic [10:0] cnt_q;

  // Count idle GET_DATA cycles, restarting on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 11'd0;
    end else if (clr_i) begin
      cnt_q <= 11'd0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + 11'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = cnt_en_i && ((cnt_q + 11'd1) == LIMIT);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream read/write command sequencer driving the configuration register file.
// Optional write-data timeout is enabled by defining REG_CMD_TIMEOUT_EN.
module reg_cmd_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int MAX_ADDR    = REG_MAX_ADDR,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_cmd_ctrl_if.slave        host,
  output logic [7:0]           reg_addr_o,
  output logic [7:0]           reg_wdata_o,
  output logic                 reg_wr_en_o,
  input  logic [7:0]           reg_rdata_i,
  output logic                 busy_o,
  output logic                 err_o
);

  state_e     state_q;
  logic       rx_ready_q;
  logic       pend_q;
  logic       cmd_wr_q;
  logic       inv_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       wr_en_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       busy_q;
  logic       err_q;
  logic       accept_s;
  logic       to_expire_s;

  assign accept_s = host.rx_valid_i && rx_ready_q;

`ifdef REG_CMD_TIMEOUT_EN
  logic to_clr_s;
  logic to_en_s;

  assign to_clr_s = (state_q == IDLE) && pend_q && cmd_wr_q;
  assign to_en_s  = (state_q == GET_DATA) && rx_ready_q && !accept_s;

  reg_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr_s),
    .cnt_en_i (to_en_s),
    .expire_o (to_expire_s)
  );
`else
  localparam logic [10:0] unused_timeout_cyc = 11'(TIMEOUT_CYC);
  assign to_expire_s = 1'b0;
`endif

  // Accepted bytes are captured at the handshake edge and acted on one cycle later (pend_q)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b1;
      pend_q     <= 1'b0;
      cmd_wr_q   <= 1'b0;
      inv_q      <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      wr_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            busy_q <= 1'b1;
            if (cmd_wr_q) begin
              state_q    <= GET_DATA;
              rx_ready_q <= 1'b1;
            end else begin
              state_q    <= READ;
              rx_ready_q <= 1'b0;
            end
          end else if (accept_s) begin
            addr_q     <= {1'b0, host.rx_data_i[6:0]};
            cmd_wr_q   <= host.rx_data_i[CMD_WR_BIT];
            inv_q      <= addr_invalid(host.rx_data_i[6:0], MAX_ADDR);
            err_q      <= addr_invalid(host.rx_data_i[6:0], MAX_ADDR);
            pend_q     <= 1'b1;
            rx_ready_q <= 1'b0;
          end else begin
            rx_ready_q <= 1'b1;
          end
        end
        GET_DATA: begin
          // Any byte here is data, even one with the write bit set
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= WRITE;
            wr_en_q <= !inv_q;
          end else if (accept_s) begin
            wdata_q    <= host.rx_data_i;
            pend_q     <= 1'b1;
            rx_ready_q <= 1'b0;
          end else if (to_expire_s) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rx_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          rx_ready_q <= 1'b1;
        end
        READ: begin
          tx_data_q  <= inv_q ? RD_ERR_DATA : reg_rdata_i;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (host.tx_ready_i) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rx_ready_q <= 1'b1;
          end else begin
            tx_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          pend_q     <= 1'b0;
          busy_q     <= 1'b0;
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign host.rx_ready_o = rx_ready_q;
  assign host.tx_data_o  = tx_data_q;
  assign host.tx_valid_o = tx_valid_q;
  assign reg_addr_o      = addr_q;
  assign reg_wdata_o     = wdata_q;
  assign reg_wr_en_o     = wr_en_q;
  assign busy_o          = busy_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: stimulus queues expected writes, responses and error pulses.
module tb_reg_cmd_ctrl;
  import reg_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_wr_en_o, busy_o, err_o;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_cmd_ctrl_if bus();

  reg_cmd_ctrl #(.MAX_ADDR(REG_MAX_ADDR), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .host(bus),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wr_en_o(reg_wr_en_o),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Small register file; out-of-range reads return a poison value
  logic [7:0] regs [REG_MAX_ADDR];
  always @(posedge clk) if (reg_wr_en_o && reg_addr_o < 8'(REG_MAX_ADDR)) regs[reg_addr_o[2:0]] <= reg_wdata_o;
  assign reg_rdata_i = (reg_addr_o < 8'(REG_MAX_ADDR)) ? regs[reg_addr_o[2:0]] : 8'hEE;

  typedef struct { logic [7:0] addr; logic [7:0] data; int at; } wr_exp_t;
  typedef struct { logic [7:0] data; int at; } tx_exp_t;
  wr_exp_t wq[$];
  tx_exp_t tq[$];
  int      eq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got event with value %0h, expected none (cycle %0d)", name, act, cyc);
  endtask

  logic tx_valid_prev = 1'b0;
  logic drop_pending  = 1'b0;

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_pending) chk("tx_valid_drop", bus.tx_valid_o, 0);
      if (reg_wr_en_o) begin
        if (wq.size() == 0) unexpected("unexpected_write", {16'd0, reg_addr_o, reg_wdata_o});
        else begin
          chk("wr_addr", reg_addr_o, wq[0].addr);
          chk("wr_data", reg_wdata_o, wq[0].data);
          chk("wr_cycle", cyc, wq[0].at);
          void'(wq.pop_front());
        end
      end
      if (err_o) begin
        if (eq.size() == 0) unexpected("unexpected_err", cyc);
        else chk("err_cycle", cyc, eq.pop_front());
      end
      if (bus.tx_valid_o) begin
        chk("rx_ready_in_send", bus.rx_ready_o, 0);
        if (tq.size() == 0) unexpected("unexpected_tx", bus.tx_data_o);
        else begin
          chk("tx_data", bus.tx_data_o, tq[0].data);
          if (!tx_valid_prev) chk("tx_rise_cycle", cyc, tq[0].at);
          if (bus.tx_ready_i) void'(tq.pop_front());
        end
      end
    end
    drop_pending  <= bus.tx_valid_o && bus.tx_ready_i;
    tx_valid_prev <= bus.tx_valid_o;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    acc = -1;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.rx_ready_o) begin
        acc = cyc + 1;
        break;
      end
      step();
    end
    if (acc < 0) unexpected("rx_accept_timeout", b);
    else step();
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input bit ok);
    int a1, a2;
    send_byte(cmd, a1);
    if (!ok) eq.push_back(a1);
    send_byte(data, a2);
    if (ok) wq.push_back('{{1'b0, cmd[6:0]}, data, a2 + 1});
    step();
    chk("write_busy", busy_o, 1);
    chk("write_rx_ready", bus.rx_ready_o, 0);
    step();
    chk("idle_after_write", busy_o, 0);
    chk("rx_ready_after_write", bus.rx_ready_o, 1);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp, input bit ok, input int hold);
    int a;
    int n;
    send_byte(cmd, a);
    tq.push_back('{exp, a + 2});
    if (!ok) eq.push_back(a);
    chk("read_rx_ready", bus.rx_ready_o, 0);
    n = 0;
    while (!bus.tx_valid_o && n < 20) begin step(); n++; end
    chk("tx_valid_seen", bus.tx_valid_o, 1);
    repeat (hold) step();
    bus.tx_ready_i = 1'b1;
    step();
    bus.tx_ready_i = 1'b0;
    step();
    chk("idle_after_read", busy_o, 0);
    chk("rx_ready_after_read", bus.rx_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    for (int i = 0; i < REG_MAX_ADDR; i++) regs[i] = 8'h00;
    rst = 1'b1;
    bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.tx_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_rx_ready", bus.rx_ready_o, 1);
    chk("rst_tx_valid", bus.tx_valid_o, 0);
    chk("rst_tx_data", bus.tx_data_o, 0);
    chk("rst_addr", reg_addr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_wr_en", reg_wr_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    step();

    do_write(8'h83, 8'h5A, 1'b1);
    do_read(8'h03, 8'h5A, 1'b1, 5);
    do_write(8'h87, 8'hA5, 1'b1);
    do_read(8'h07, 8'hA5, 1'b1, 0);
    do_write(8'h80, 8'h9C, 1'b1);
    do_read(8'h00, 8'h9C, 1'b1, 2);
    do_write(8'h8A, 8'h11, 1'b0);
    do_read(8'h0A, RD_ERR_DATA, 1'b0, 1);
    do_read(8'h08, RD_ERR_DATA, 1'b0, 0);
    do_write(8'h81, 8'hC3, 1'b1);
    do_read(8'h01, 8'hC3, 1'b1, 0);

    // Reset while waiting for write data
    send_byte(8'h81, a);
    step();
    chk("getdata_busy", busy_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_addr", reg_addr_o, 0);
    chk("midrst_rx_ready", bus.rx_ready_o, 1);
    do_read(8'h22, RD_ERR_DATA, 1'b0, 0);

`ifdef REG_CMD_TIMEOUT_EN
    send_byte(8'h82, a);
    eq.push_back(a + 16);
    repeat (16) step();
    chk("timeout_idle", busy_o, 0);
    step();
    send_byte(8'h82, a);
    repeat (15) step();
    chk("late_data_busy", busy_o, 1);
    begin
      int a2;
      send_byte(8'h6E, a2);
      chk("late_data_accept", a2, a + 16);
      wq.push_back('{8'h02, 8'h6E, a2 + 1});
    end
    repeat (3) step();
    chk("late_data_idle", busy_o, 0);
`endif

    repeat (4) step();
    chk("wq_drained", wq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
